// File: rtl/drink_pkg.sv
// rtl/drink_pkg.sv - coin codes, station states and default pricing for the drink scheduler
package drink_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        HALF   = 2'd1,
        ONE    = 2'd2,
        CANCEL = 2'd3
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SERVE = 2'd2
    } st_e;

    localparam int DEF_PRICE       = 3;
    localparam int DEF_DISP_CYCLES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational N-way round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr_next
);

    logic found;
    int   idx;

    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_next = PW'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/drink_sched.sv
// rtl/drink_sched.sv - coin stations sharing one dispenser through a round-robin grant
module drink_sched
    import drink_pkg::*;
#(
    parameter int N_ST        = 2,
    parameter int PRICE       = DEF_PRICE,
    parameter int DISP_CYCLES = DEF_DISP_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*N_ST-1:0]   coin,
    output logic [N_ST-1:0]     coin_ok,
    output logic [N_ST-1:0]     drink,
    output logic [3*N_ST-1:0]   back,
    output logic                disp_busy
);

    localparam int PW = (N_ST > 1) ? $clog2(N_ST) : 1;
    localparam int CW = $clog2(DISP_CYCLES + 1);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [N_ST-1:0] req;
    logic [N_ST-1:0] gnt;
    logic [CW-1:0]   cnt;
    logic            busy_r;
    logic            fin;

    // Last busy cycle: the serving station pays out and the dispenser frees at this edge.
    assign fin       = busy_r && (cnt == CW'(1));
    assign disp_busy = busy_r;

    rr_arbiter #(.N(N_ST), .PW(PW)) u_arb (
        .req      (req),
        .ptr      (ptr),
        .gnt      (gnt),
        .ptr_next (ptr_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr    <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
        end else begin
            ptr <= ptr_next;
            if (|gnt) begin
                cnt    <= CW'(DISP_CYCLES);
                busy_r <= 1'b1;
            end else if (busy_r) begin
                cnt <= cnt - CW'(1);
                if (fin) busy_r <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < N_ST; i++) begin : g_st
        st_e        st;
        coin_e      c;
        logic [2:0] credit;
        logic [2:0] credit_add;
        logic [2:0] back_r;
        logic       drink_r;

        assign c = coin_e'(coin[2*i +: 2]);

        always_comb begin
            credit_add = credit;
            if (c == HALF)     credit_add = credit + 3'd1;
            else if (c == ONE) credit_add = credit + 3'd2;
        end

        // A cancel in the grant cycle withdraws the request so the refund wins.
        assign req[i] = (st == ST_WAIT) && (c != CANCEL) && !busy_r;

        always_ff @(posedge clk) begin
            if (!reset) begin
                st      <= ST_IDLE;
                credit  <= 3'd0;
                drink_r <= 1'b0;
                back_r  <= 3'd0;
            end else begin
                drink_r <= 1'b0;
                back_r  <= 3'd0;
                case (st)
                    ST_IDLE: begin
                        if (c == CANCEL) begin
                            back_r <= credit;
                            credit <= 3'd0;
                        end else begin
                            credit <= credit_add;
                            if (credit_add >= 3'(PRICE)) st <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (c == CANCEL) begin
                            back_r <= credit;
                            credit <= 3'd0;
                            st     <= ST_IDLE;
                        end else if (gnt[i]) begin
                            st <= ST_SERVE;
                        end
                    end
                    ST_SERVE: begin
                        if (fin) begin
                            drink_r <= 1'b1;
                            back_r  <= credit - 3'(PRICE);
                            credit  <= 3'd0;
                            st      <= ST_IDLE;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end

        assign coin_ok[i]      = (st == ST_IDLE);
        assign drink[i]        = drink_r;
        assign back[3*i +: 3]  = back_r;
    end

endmodule

// File: tb/tb_drink_sched.sv
// tb/tb_drink_sched.sv - directed self-checking bench for drink_sched (2 stations, price 3, 2-cycle dispense)
module tb_drink_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] coin;
    logic [1:0] coin_ok;
    logic [1:0] drink;
    logic [5:0] back;
    logic       disp_busy;

    int n_checks = 0;
    int n_fail   = 0;

    drink_sched #(.N_ST(2), .PRICE(3), .DISP_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .coin      (coin),
        .coin_ok   (coin_ok),
        .drink     (drink),
        .back      (back),
        .disp_busy (disp_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        coin  = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        coin  = 4'b0000;
        do_reset();
        check("rst_coin_ok", coin_ok, 2'b11);
        check("rst_drink", drink, 2'b00);
        check("rst_back", back, 6'd0);
        check("rst_busy", disp_busy, 1'b0);

        // cancel with zero credit: no refund
        coin = 4'b0011; tick();
        check("cancel0_back", back, 6'd0);

        // station 0: 2 then 1, exact price
        coin = 4'b0010; tick();
        check("a_idle", coin_ok, 2'b11);
        coin = 4'b0001; tick();
        check("a_wait", coin_ok, 2'b10);
        check("a_nobusy", disp_busy, 1'b0);
        coin = 4'b0000; tick();
        check("a_grant_busy", disp_busy, 1'b1);
        tick();
        check("a_busy2", disp_busy, 1'b1);
        check("a_nodrink", drink, 2'b00);
        tick();
        check("a_drink", drink, 2'b01);
        check("a_back", back, 6'd0);
        check("a_busy_fall", disp_busy, 1'b0);
        check("a_idle_again", coin_ok, 2'b11);
        tick();
        check("a_drink_off", drink, 2'b00);

        // station 0: 2,2 -> change of one half-unit; coin in SERVE ignored
        coin = 4'b0010; tick();
        coin = 4'b0010; tick();
        check("b_wait", coin_ok, 2'b10);
        coin = 4'b0000; tick();
        check("b_busy", disp_busy, 1'b1);
        coin = 4'b0001; tick();
        check("b_serve_coin_ok", coin_ok, 2'b10);
        check("b_serve_nodrink", drink, 2'b00);
        coin = 4'b0000; tick();
        check("b_drink", drink, 2'b01);
        check("b_back", back, 6'b000001);
        tick();
        check("b_back_off", back, 6'd0);

        // both stations wait together after reset: 0 first, 1 next, then 0 first again
        for (int rep = 0; rep < 2; rep++) begin
            if (rep == 0) do_reset();
            coin = 4'b1010; tick();
            coin = 4'b0101; tick();
            check("c_both_wait", coin_ok, 2'b00);
            coin = 4'b0000; tick();
            check("c_busy0", disp_busy, 1'b1);
            tick();
            tick();
            check("c_drink0", drink, 2'b01);
            check("c_coin_ok0", coin_ok, 2'b01);
            tick();
            check("c_grant1_busy", disp_busy, 1'b1);
            check("c_grant1_nodrink", drink, 2'b00);
            tick();
            tick();
            check("c_drink1", drink, 2'b10);
            tick();
        end

        // station 1: half unit then cancel -> refund 1
        coin = 4'b0100; tick();
        coin = 4'b1100; tick();
        check("d_refund1", back, 6'b001000);
        check("d_nodrink", drink, 2'b00);
        coin = 4'b0000; tick();
        check("d_refund_off", back, 6'd0);

        // solo serve of station 0 moves the pointer to station 1
        coin = 4'b0010; tick();
        coin = 4'b0001; tick();
        coin = 4'b0000; tick();
        tick();
        tick();
        check("d_solo_drink", drink, 2'b01);
        // both wait; station 1 cancels in the grant cycle despite having priority
        coin = 4'b1010; tick();
        coin = 4'b0101; tick();
        coin = 4'b1100; tick();
        check("d_cancel_back", back, 6'b011000);
        check("d_cancel_busy", disp_busy, 1'b1);
        check("d_cancel_coin_ok", coin_ok, 2'b10);
        coin = 4'b0000; tick();
        tick();
        check("d_other_drink", drink, 2'b01);
        tick();

        // reset one cycle after a grant aborts the dispense
        coin = 4'b0010; tick();
        coin = 4'b0001; tick();
        coin = 4'b0000; tick();
        check("e_busy", disp_busy, 1'b1);
        reset = 1'b0; tick();
        check("e_rst_busy", disp_busy, 1'b0);
        check("e_rst_coin_ok", coin_ok, 2'b11);
        check("e_rst_drink", drink, 2'b00);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("e_no_drink", drink, 2'b00);
            check("e_no_back", back, 6'd0);
        end
        coin = 4'b0001; tick();
        coin = 4'b0011; tick();
        check("e_credit_lost", back, 6'b000001);
        coin = 4'b0000; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
